// File: rtl/max_value_cache.sv
// Per-channel windowed peak-magnitude tracker with a read-out cache.
// Four signed channels are reduced to saturated magnitudes; each window of
// WINDOW_LEN samples yields a peak value and the sample offset where it first
// occurred. A snapshot of those results is served to the SPI cache controller
// one cycle after each read request, together with a per-channel "fresh" flag.
module max_value_cache #(
    parameter int DATA_W     = 16,
    parameter int WINDOW_LEN = 1024,
    parameter int IDX_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] ch1_sample,
    input  logic signed [DATA_W-1:0] ch2_sample,
    input  logic signed [DATA_W-1:0] ch3_sample,
    input  logic signed [DATA_W-1:0] ch4_sample,
    input  logic        [2:0]        Max_Value_Channel_sel,
    input  logic                     read_req,
    output logic        [DATA_W-1:0] max_value,
    output logic        [IDX_W-1:0]  max_index,
    output logic                     max_fresh,
    output logic                     read_valid,
    output logic                     window_done
);

    localparam int NUM_CH = 4;
    localparam int CNT_W  = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    // |s| for a two's-complement sample; the most negative code has no
    // positive counterpart and saturates to the largest positive value.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] s);
        if (s == MOST_NEG) begin
            return MOST_POS;
        end else if (s[DATA_W-1]) begin
            return ~s + ONE;
        end else begin
            return s;
        end
    endfunction

    logic [DATA_W-1:0] sample_vec [NUM_CH];
    logic [CNT_W-1:0]  sample_cnt;
    logic [DATA_W-1:0] run_peak   [NUM_CH];
    logic [IDX_W-1:0]  run_idx    [NUM_CH];
    logic [DATA_W-1:0] next_peak  [NUM_CH];
    logic [IDX_W-1:0]  next_idx   [NUM_CH];
    logic [DATA_W-1:0] snap_peak  [NUM_CH];
    logic [IDX_W-1:0]  snap_idx   [NUM_CH];
    logic [NUM_CH-1:0] fresh;
    logic              window_end;
    logic              sel_valid;
    logic [1:0]        sel_ch;

    // Gather the channel inputs into an array so the per-channel logic can loop.
    always_comb begin
        sample_vec[0] = ch1_sample;
        sample_vec[1] = ch2_sample;
        sample_vec[2] = ch3_sample;
        sample_vec[3] = ch4_sample;
    end

    // Control decode: last-sample detection and read channel selection.
    always_comb begin
        window_end = sample_valid && (sample_cnt == LAST_CNT);
        sel_valid  = (Max_Value_Channel_sel >= 3'd1) && (Max_Value_Channel_sel <= 3'd4);
        // Codes 1..4 map to array slots 0..3 using only the low two bits.
        sel_ch     = Max_Value_Channel_sel[1:0] - 2'd1;
    end

    // Peak candidates including the current sample (strictly-greater keeps
    // the earliest index on ties).
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
            next_peak[c] = run_peak[c];
            next_idx[c]  = run_idx[c];
            if (magnitude(sample_vec[c]) > run_peak[c]) begin
                next_peak[c] = magnitude(sample_vec[c]);
                next_idx[c]  = IDX_W'(sample_cnt);
            end
        end
    end

    // Window counter and running peaks; everything clears at the end of a window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt <= '0;
            // NOTE: these small register arrays are reset explicitly; they are flops, not RAM, and must read as 0.
            for (int c = 0; c < NUM_CH; c++) begin
                run_peak[c] <= '0;
                run_idx[c]  <= '0;
            end
        end else if (sample_valid) begin
            if (window_end) begin
                sample_cnt <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    run_peak[c] <= '0;
                    run_idx[c]  <= '0;
                end
            end else begin
                // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
                sample_cnt <= sample_cnt + CNT_ONE;
                for (int c = 0; c < NUM_CH; c++) begin
                    run_peak[c] <= next_peak[c];
                    run_idx[c]  <= next_idx[c];
                end
            end
        end
    end

    // Snapshot capture and fresh flags; a snapshot outranks a read's clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            fresh       <= '0;
            window_done <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                snap_peak[c] <= '0;
                snap_idx[c]  <= '0;
            end
        end else begin
            window_done <= window_end;
            if (window_end) begin
                fresh <= '1;
                for (int c = 0; c < NUM_CH; c++) begin
                    snap_peak[c] <= next_peak[c];
                    snap_idx[c]  <= next_idx[c];
                end
            end else if (read_req && sel_valid) begin
                fresh[sel_ch] <= 1'b0;
            end
        end
    end

    // Read port: one-cycle latency from the pre-edge snapshot; results hold between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid <= 1'b0;
            max_value  <= '0;
            max_index  <= '0;
            max_fresh  <= 1'b0;
        end else begin
            read_valid <= read_req;
            if (read_req) begin
                if (sel_valid) begin
                    max_value <= snap_peak[sel_ch];
                    max_index <= snap_idx[sel_ch];
                    max_fresh <= fresh[sel_ch];
                end else begin
                    max_value <= '0;
                    max_index <= '0;
                    max_fresh <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_max_value_cache.sv
// Bench for max_value_cache with WINDOW_LEN=4. A behavioural model stores the
// magnitudes of each window in plain arrays and picks the peak by scanning
// them when the window completes; the read side is modelled as a lookup.
module tb_max_value_cache;

    localparam int DATA_W     = 16;
    localparam int WINDOW_LEN = 4;
    localparam int IDX_W      = 16;
    localparam int SAT_MAX    = (1 << (DATA_W - 1)) - 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     sample_valid;
    logic signed [DATA_W-1:0] ch1_sample, ch2_sample, ch3_sample, ch4_sample;
    logic        [2:0]        Max_Value_Channel_sel;
    logic                     read_req;
    logic        [DATA_W-1:0] max_value;
    logic        [IDX_W-1:0]  max_index;
    logic                     max_fresh;
    logic                     read_valid;
    logic                     window_done;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int m_win [4][WINDOW_LEN];
    int m_count;
    int m_snap_val [4];
    int m_snap_idx [4];
    bit m_fresh [4];
    int exp_value, exp_index;
    bit exp_fresh, exp_rv, exp_wd;

    always #5 clk = ~clk;

    max_value_cache #(
        .DATA_W     (DATA_W),
        .WINDOW_LEN (WINDOW_LEN),
        .IDX_W      (IDX_W)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .sample_valid          (sample_valid),
        .ch1_sample            (ch1_sample),
        .ch2_sample            (ch2_sample),
        .ch3_sample            (ch3_sample),
        .ch4_sample            (ch4_sample),
        .Max_Value_Channel_sel (Max_Value_Channel_sel),
        .read_req              (read_req),
        .max_value             (max_value),
        .max_index             (max_index),
        .max_fresh             (max_fresh),
        .read_valid            (read_valid),
        .window_done           (window_done)
    );

    function automatic int mag_of(input logic signed [DATA_W-1:0] s);
        int v;
        v = s;
        if (v < 0) v = -v;
        if (v > SAT_MAX) v = SAT_MAX;
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle #1.
    task automatic step(input bit rst, input bit sv, input int s1, input int s2,
                        input int s3, input int s4, input bit rr, input int sel);
        int best, best_i;
        reset                 = rst;
        sample_valid          = sv;
        ch1_sample            = DATA_W'(s1);
        ch2_sample            = DATA_W'(s2);
        ch3_sample            = DATA_W'(s3);
        ch4_sample            = DATA_W'(s4);
        read_req              = rr;
        Max_Value_Channel_sel = 3'(sel);
        @(posedge clk);
        if (rst) begin
            m_count = 0;
            for (int c = 0; c < 4; c++) begin
                m_snap_val[c] = 0;
                m_snap_idx[c] = 0;
                m_fresh[c]    = 1'b0;
            end
            exp_value = 0; exp_index = 0; exp_fresh = 1'b0;
            exp_rv = 1'b0; exp_wd = 1'b0;
        end else begin
            exp_rv = rr;
            exp_wd = 1'b0;
            if (rr) begin
                if (sel >= 1 && sel <= 4) begin
                    exp_value = m_snap_val[sel-1];
                    exp_index = m_snap_idx[sel-1];
                    exp_fresh = m_fresh[sel-1];
                    m_fresh[sel-1] = 1'b0;
                end else begin
                    exp_value = 0; exp_index = 0; exp_fresh = 1'b0;
                end
            end
            if (sv) begin
                m_win[0][m_count] = mag_of(ch1_sample);
                m_win[1][m_count] = mag_of(ch2_sample);
                m_win[2][m_count] = mag_of(ch3_sample);
                m_win[3][m_count] = mag_of(ch4_sample);
                m_count++;
                if (m_count == WINDOW_LEN) begin
                    for (int c = 0; c < 4; c++) begin
                        best = 0; best_i = 0;
                        for (int i = 0; i < WINDOW_LEN; i++)
                            if (m_win[c][i] > best) begin
                                best = m_win[c][i];
                                best_i = i;
                            end
                        m_snap_val[c] = best;
                        m_snap_idx[c] = best_i;
                        m_fresh[c]    = 1'b1;
                    end
                    m_count = 0;
                    exp_wd  = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int sel);
        step(0, 0, 0, 0, 0, 0, 1, sel);
    endtask

    task automatic test_reset();
        step(1, 1, 5, 5, 5, 5, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if ({max_value, max_index, max_fresh, read_valid, window_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got val=%0d idx=%0d fresh=%0b rv=%0b wd=%0b, expected all 0",
                     max_value, max_index, max_fresh, read_valid, window_done);
        end
        for (int s = 1; s <= 4; s++) begin
            rd(s);
            tests_run++;
            if (read_valid !== 1'b1 || max_value !== '0 || max_index !== '0 || max_fresh !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_snapshot_ch%0d: got rv=%0b val=%0d idx=%0d fresh=%0b, expected rv=1 val=0 idx=0 fresh=0",
                         s, read_valid, max_value, max_index, max_fresh);
            end
        end
    endtask

    task automatic test_basic_window();
        int ch1 [4] = '{5, -9, 9, 3};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, ch1[i], 0, 0, 0, 0, 0);
            tests_run++;
            if (window_done !== (i == 3)) begin
                tests_failed++;
                $display("FAIL window_done_at_%0d: got %0b expected %0b", i, window_done, (i == 3));
            end
        end
        idle();
        tests_run++;
        if (window_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL window_done_single_pulse: got %0b expected 0", window_done);
        end
        rd(1);
        tests_run++;
        if (read_valid !== 1'b1 || max_value !== 16'd9 || max_index !== 16'd1 || max_fresh !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_read_ch1: got rv=%0b val=%0d idx=%0d fresh=%0b, expected rv=1 val=9 idx=1 fresh=1",
                     read_valid, max_value, max_index, max_fresh);
        end
        idle();
        tests_run++;
        if (read_valid !== 1'b0 || max_value !== 16'd9 || max_index !== 16'd1 || max_fresh !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_between_reads: got rv=%0b val=%0d idx=%0d fresh=%0b, expected rv=0 val=9 idx=1 fresh=1",
                     read_valid, max_value, max_index, max_fresh);
        end
        rd(1);
        tests_run++;
        if (read_valid !== 1'b1 || max_value !== 16'd9 || max_index !== 16'd1 || max_fresh !== 1'b0) begin
            tests_failed++;
            $display("FAIL reread_ch1: got rv=%0b val=%0d idx=%0d fresh=%0b, expected rv=1 val=9 idx=1 fresh=0",
                     read_valid, max_value, max_index, max_fresh);
        end
    endtask

    task automatic test_saturation();
        int ch2 [4] = '{100, -32768, 32767, 5};
        for (int i = 0; i < 4; i++) step(0, 1, 0, ch2[i], 0, 0, 0, 0);
        rd(2);
        tests_run++;
        if (max_value !== 16'h7FFF || max_index !== 16'd1 || max_fresh !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturate_ch2: got val=%h idx=%0d fresh=%0b, expected val=7fff idx=1 fresh=1",
                     max_value, max_index, max_fresh);
        end
    endtask

    task automatic test_read_on_snapshot();
        int a [4] = '{7, 0, -20, 3};
        int b [4] = '{1, 2, 3, -30};
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, a[i], 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, b[i], 0, 0, 0);
        step(0, 1, 0, 0, b[3], 0, 1, 3);
        tests_run++;
        if (read_valid !== 1'b1 || max_value !== 16'd20 || max_index !== 16'd2 || max_fresh !== 1'b1 || window_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_on_snapshot_old: got rv=%0b val=%0d idx=%0d fresh=%0b wd=%0b, expected rv=1 val=20 idx=2 fresh=1 wd=1",
                     read_valid, max_value, max_index, max_fresh, window_done);
        end
        rd(3);
        tests_run++;
        if (max_value !== 16'd30 || max_index !== 16'd3 || max_fresh !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_after_snapshot_new: got val=%0d idx=%0d fresh=%0b, expected val=30 idx=3 fresh=1",
                     max_value, max_index, max_fresh);
        end
    endtask

    task automatic test_bad_select();
        int sels [2] = '{0, 7};
        for (int k = 0; k < 2; k++) begin
            rd(1);
            rd(sels[k]);
            tests_run++;
            if (read_valid !== 1'b1 || max_value !== '0 || max_index !== '0 || max_fresh !== 1'b0) begin
                tests_failed++;
                $display("FAIL bad_sel_%0d: got rv=%0b val=%0d idx=%0d fresh=%0b, expected rv=1 val=0 idx=0 fresh=0",
                         sels[k], read_valid, max_value, max_index, max_fresh);
            end
        end
        // ch4 has not been read since its last snapshot; invalid selects must not have touched it.
        rd(4);
        tests_run++;
        if (max_fresh !== 1'b1 || max_value !== 16'(exp_value)) begin
            tests_failed++;
            $display("FAIL bad_sel_flags_kept: got val=%0d fresh=%0b, expected val=%0d fresh=1",
                     max_value, max_fresh, exp_value);
        end
    endtask

    task automatic test_reset_mid_window();
        int pulses = 0;
        step(0, 1, 50, 50, 50, 50, 0, 0);
        step(0, 1, 60, 60, 60, 60, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0, 0, i, 0, 0);
            if (window_done === 1'b1) pulses++;
            tests_run++;
            if (window_done !== (i == 4)) begin
                tests_failed++;
                $display("FAIL mid_reset_wd_sample%0d: got %0b expected %0b", i, window_done, (i == 4));
            end
        end
        idle();
        if (window_done === 1'b1) pulses++;
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL mid_reset_pulse_count: got %0d expected 1", pulses);
        end
        rd(4);
        tests_run++;
        if (max_value !== 16'd4 || max_index !== 16'd3 || max_fresh !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_read_ch4: got val=%0d idx=%0d fresh=%0b, expected val=4 idx=3 fresh=1",
                     max_value, max_index, max_fresh);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < WINDOW_LEN; i++)
            step(0, 1, $urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000,
                 $urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000, 0, 0);
        for (int s = 1; s <= 4; s++) begin
            rd(s);
            tests_run++;
            if (read_valid !== 1'b1 || max_value !== 16'(exp_value) || max_index !== 16'(exp_index) || max_fresh !== exp_fresh) begin
                tests_failed++;
                $display("FAIL back_to_back_ch%0d: got rv=%0b val=%0d idx=%0d fresh=%0b, expected rv=1 val=%0d idx=%0d fresh=%0b",
                         s, read_valid, max_value, max_index, max_fresh, exp_value, exp_index, exp_fresh);
            end
        end
    endtask

    function automatic int rand_sample();
        case ($urandom_range(0, 9))
            0:       return -32768;
            1:       return 32767;
            2:       return 0;
            3, 4:    return $urandom_range(0, 65535) - 32768;
            default: return $urandom_range(0, 40) - 20;
        endcase
    endfunction

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 rand_sample(), rand_sample(), rand_sample(), rand_sample(),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7));
            tests_run++;
            if (read_valid !== exp_rv || window_done !== exp_wd || max_value !== 16'(exp_value) ||
                max_index !== 16'(exp_index) || max_fresh !== exp_fresh) begin
                tests_failed++;
                if (errs < 10)
                    $display("FAIL random_cycle_%0d: got rv=%0b wd=%0b val=%0d idx=%0d fresh=%0b, expected rv=%0b wd=%0b val=%0d idx=%0d fresh=%0b",
                             n, read_valid, window_done, max_value, max_index, max_fresh,
                             exp_rv, exp_wd, exp_value, exp_index, exp_fresh);
                errs++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; read_req = 1'b0;
        ch1_sample = '0; ch2_sample = '0; ch3_sample = '0; ch4_sample = '0;
        Max_Value_Channel_sel = '0;
        test_reset();
        test_basic_window();
        test_saturation();
        test_read_on_snapshot();
        test_bad_select();
        test_reset_mid_window();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/max_value_cache.md
MAX_VALUE_CACHE -- requirements
Module: max_value_cache

Interface
REQ-001 SHALL expose parameter DATA_W, default 16, sample width in bits (signed two's complement).
REQ-002 SHALL expose parameter WINDOW_LEN, default 1024, samples per peak window (range 2..65535).
REQ-003 SHALL expose parameter IDX_W, default 16, width of the peak index.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sample_valid  input  1  one-cycle strobe; all four channel samples valid this cycle.
REQ-007 ch1_sample..ch4_sample  input  DATA_W each  signed channel samples.
REQ-008 Max_Value_Channel_sel  input  3  channel select from the SPI cache controller: 1..4 = channel 1..4, all other codes = none.
REQ-009 read_req  input  1  one-cycle read strobe.
REQ-010 max_value  output  DATA_W  unsigned peak magnitude returned by the last read.
REQ-011 max_index  output  IDX_W  sample offset within the window at which that peak occurred.
REQ-012 max_fresh  output  1  returned peak not previously read.
REQ-013 read_valid  output  1  one-cycle strobe; max_value, max_index and max_fresh are valid.
REQ-014 window_done  output  1  one-cycle strobe when a window snapshot is taken.

Function
REQ-015 Per channel, magnitude SHALL be |sample|; -2^(DATA_W-1) SHALL saturate to 2^(DATA_W-1)-1.
REQ-016 A window sample counter SHALL count 0..WINDOW_LEN-1 and advance only on sample_valid.
REQ-017 Per channel, the running peak and running index SHALL update only when the magnitude is strictly greater than the running peak; ties keep the earliest index.
REQ-018 On the sample_valid where the counter equals WINDOW_LEN-1:
- that sample SHALL be included in the ending window;
- the resulting peak/index per channel SHALL be copied to the snapshot registers;
- all four fresh flags SHALL be set;
- running peaks SHALL clear to 0, running indices to 0, and the counter to 0;
- window_done SHALL pulse in the next cycle.
REQ-019 The first sample of every window SHALL always load the running peak (it compares against 0 with a strictly-greater rule, so a zero sample leaves peak 0 and index 0).
REQ-020 A read SHALL use only the snapshot registers, never the running values.
REQ-021 read_req with sel 1..4 in cycle N SHALL produce, in cycle N+1:
- read_valid=1;
- max_value and max_index from that channel's snapshot;
- max_fresh equal to that channel's fresh flag as of cycle N.
The fresh flag SHALL then clear.
REQ-022 read_req with sel 0, 5, 6 or 7 SHALL pulse read_valid with max_value=0, max_index=0 and max_fresh=0; no flag changes.
REQ-023 If read_req and a snapshot occur in the same cycle, the read SHALL return the pre-snapshot contents and flag, and the fresh flag SHALL end set (the snapshot wins over the clear).
REQ-024 max_value, max_index and max_fresh SHALL hold between reads; read_valid and window_done SHALL be single-cycle strobes.
REQ-025 Back-to-back read_req on consecutive cycles SHALL each be serviced with 1-cycle latency; no request is dropped.
REQ-026 Snapshots before the first completed window SHALL read as value 0, index 0, fresh 0.

Reset
REQ-027 While reset is high, all of the following SHALL be 0 on the next edge: counter, running peaks and indices, snapshots, fresh flags, max_value, max_index, max_fresh, read_valid, window_done.
REQ-028 Reset asserted mid-window SHALL discard the partial window; the first sample_valid after reset SHALL be index 0.
REQ-029 read_req and sample_valid SHALL be ignored in any cycle in which reset is high.

Verification
REQ-030 WINDOW_LEN=4. Ch1 samples 5, -9, 9, 3 -> window_done pulses; read sel=1 -> read_valid next cycle, max_value=9, max_index=1, max_fresh=1.
REQ-031 Read sel=1 again with no new window -> max_value=9, max_index=1, max_fresh=0.
REQ-032 Ch2 sample 16'h8000 within a window -> read sel=2 after window_done gives max_value=16'h7FFF.
REQ-033 read_req sel=3 in the same cycle as the snapshot edge -> returns the previous window's ch3 values; a following read returns the new values with max_fresh=1.
REQ-034 read_req with sel=0 and with sel=7 -> read_valid=1, all read outputs 0, fresh flags unchanged.
REQ-035 Feed 2 samples, assert reset for 1 cycle, then feed 4 samples of 1, 2, 3, 4 on ch4 -> exactly one window_done after the 4th sample; read sel=4 gives max_value=4, max_index=3.
